// File: rtl/pipeline_pkg.sv
// Shared fetch-to-decode pipeline definitions: the payload carried between the
// fetch and decode stages, its packed width, and a small pointer helper.
// Optional feature of stage_buffer: STAGE_BUFFER_BYPASS_EN (0-cycle bypass).
package pipeline_pkg;

  // PC is word aligned, so its two low bits are implied and not carried.
  localparam int PC_W    = 30;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic               pc_valid;
    logic [PC_W-1:0]    pc;
    logic               instruction_valid;
    logic [INSTR_W-1:0] instruction;
  } fd_payload_t;

  localparam int FD_WIDTH = $bits(fd_payload_t);

  // Circular pointer increment that wraps at any depth, not just powers of two.
  function automatic int wrap_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/stage_buffer.sv
// stage_buffer: small circular FIFO between two pipeline stages with
// valid/stall handshakes, a head-hold input and a flush.
// Define STAGE_BUFFER_BYPASS_EN to let an empty buffer pass the upstream
// offer straight through in the same cycle.
module stage_buffer
  import pipeline_pkg::*;
#(
  parameter int WIDTH = FD_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       prev_done,
  output logic                       stall_prev,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       next_stall,
  output logic                       done_next,
  output logic [WIDTH-1:0]           data_out,
  input  logic                       hold,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_empty;
  logic             w_full;
  logic             w_xfer_prev;
  logic             w_xfer_next;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_head  = r_mem[r_rd_ptr];

`ifdef STAGE_BUFFER_BYPASS_EN
  // Empty buffer forwards the upstream offer combinationally.
  assign done_next = !rst && !flush && !hold && (!w_empty || prev_done);
  assign data_out  = w_empty ? data_in : w_head;
  // An entry that goes in and out in the same cycle is never stored.
  assign w_bypass  = w_empty && w_xfer_next;
`else
  assign done_next = !rst && !flush && !hold && !w_empty;
  assign data_out  = w_head;
  assign w_bypass  = 1'b0;
`endif

  assign w_xfer_next = done_next && !next_stall;
  // A full buffer still accepts when it is releasing its head this cycle.
  assign stall_prev  = rst || (w_full && !w_xfer_next);
  assign w_xfer_prev = prev_done && !stall_prev;

  // Flush discards whatever is accepted in the same cycle.
  assign w_push = w_xfer_prev && !flush && !w_bypass;
  assign w_pop  = w_xfer_next && !w_bypass;

  assign count = r_count;

  // Payload storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_in;
  end

  // Pointers and occupancy; reset beats flush, flush beats transfers.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= PTR_W'(wrap_inc(int'(r_wr_ptr), DEPTH));
      if (w_pop)  r_rd_ptr <= PTR_W'(wrap_inc(int'(r_rd_ptr), DEPTH));
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_buffer.sv
// Bench for stage_buffer: a DEPTH=2 and a DEPTH=3 instance share one set of
// inputs. A directed vector table checks DEPTH=2 against hand-derived
// values, a list-based reference model checks both instances every cycle,
// and a random phase follows.
module tb_stage_buffer;
  import pipeline_pkg::*;

`ifdef STAGE_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int W = 64;

  typedef struct {
    bit         rst, pd, ns, hold, flush;
    logic [W-1:0] din;
    bit         e_done, e_stall;
    logic [W-1:0] e_data;
    int         e_cnt;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst, prev_done, next_stall, hold, flush;
  logic [W-1:0] data_in;
  logic         o_stall [2];
  logic         o_done  [2];
  logic [W-1:0] o_data  [2];
  logic [1:0]   o_cnt   [2];

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: occupancy list per instance, head at index 0.
  int           dep [2] = '{2, 3};
  logic [W-1:0] mlist [2][4];
  int           mcnt [2];

  bit           cap_en = 1'b0;
  logic [W-1:0] emitted [$];

  always #5 clk = ~clk;

  stage_buffer #(.WIDTH(W), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .prev_done(prev_done), .stall_prev(o_stall[0]),
    .data_in(data_in), .next_stall(next_stall), .done_next(o_done[0]),
    .data_out(o_data[0]), .hold(hold), .flush(flush), .count(o_cnt[0]));

  stage_buffer #(.WIDTH(W), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .prev_done(prev_done), .stall_prev(o_stall[1]),
    .data_in(data_in), .next_stall(next_stall), .done_next(o_done[1]),
    .data_out(o_data[1]), .hold(hold), .flush(flush), .count(o_cnt[1]));

  task automatic cmp(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit r, bit pd, logic [W-1:0] din, bit ns, bit h, bit f,
                              bit ed, logic [W-1:0] edata, bit es, int ec);
    vec_t v;
    v.rst = r; v.pd = pd; v.din = din; v.ns = ns; v.hold = h; v.flush = f;
    v.e_done = ed; v.e_data = edata; v.e_stall = es; v.e_cnt = ec;
    return v;
  endfunction

  // Apply one cycle of inputs (entered at a falling edge), check outputs
  // mid-cycle, then advance the model across the rising edge.
  task automatic step(input vec_t v, input bit tab, input string tag);
    int           ncnt [2];
    logic [W-1:0] nlist [2][4];
    rst = v.rst; prev_done = v.pd; data_in = v.din;
    next_stall = v.ns; hold = v.hold; flush = v.flush;
    #1;
    if (tab) begin
      cmp({tag, " d2 count"}, W'(o_cnt[0]), W'(v.e_cnt));
      cmp({tag, " d2 done_next"}, W'(o_done[0]), W'(v.e_done));
      cmp({tag, " d2 stall_prev"}, W'(o_stall[0]), W'(v.e_stall));
      if (v.e_done) cmp({tag, " d2 data_out"}, o_data[0], v.e_data);
    end
    for (int d = 0; d < 2; d++) begin
      int           c;
      bit           e_done, e_stall, xn, xp;
      logic [W-1:0] e_data;
      string        nm;
      c       = mcnt[d];
      nm      = (d == 0) ? "model d2" : "model d3";
      e_done  = !v.rst && !v.flush && !v.hold && (c != 0 || (BYP && v.pd));
      e_data  = (c != 0) ? mlist[d][0] : v.din;
      xn      = e_done && !v.ns;
      e_stall = v.rst || (c == dep[d] && !xn);
      xp      = v.pd && !e_stall;
      cmp({nm, " count"}, W'(o_cnt[d]), W'(c));
      cmp({nm, " done_next"}, W'(o_done[d]), W'(e_done));
      cmp({nm, " stall_prev"}, W'(o_stall[d]), W'(e_stall));
      if (e_done) cmp({nm, " data_out"}, o_data[d], e_data);
      if (d == 1 && cap_en && xn) emitted.push_back(e_data);
      nlist[d] = mlist[d];
      ncnt[d]  = c;
      if (v.rst || v.flush) ncnt[d] = 0;
      else begin
        if (xn && c != 0) begin
          for (int i = 0; i < 3; i++) nlist[d][i] = nlist[d][i+1];
          ncnt[d]--;
        end
        if (xp && !(c == 0 && xn)) begin
          nlist[d][ncnt[d]] = v.din;
          ncnt[d]++;
        end
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      mcnt[d]  = ncnt[d];
      mlist[d] = nlist[d];
    end
    @(negedge clk);
  endtask

  vec_t tab [$];
  vec_t idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mcnt[0] = 0; mcnt[1] = 0;
    rst = 1'b1; prev_done = 1'b0; next_stall = 1'b0; hold = 1'b0; flush = 1'b0; data_in = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);

    // Directed DEPTH=2 sequence: reset, fill/stall, full push+pop, flush,
    // hold, bypass latency, mid-run reset.
    tab.push_back(mk(1, 0, 0,     0, 0, 0, 0,    0,     1, 0));
    tab.push_back(mk(0, 1, 'hA,   1, 0, 0, BYP,  'hA,   0, 0));
    tab.push_back(mk(0, 1, 'hB,   1, 0, 0, 1,    'hA,   0, 1));
    tab.push_back(mk(0, 0, 0,     1, 0, 0, 1,    'hA,   1, 2));
    tab.push_back(mk(0, 1, 'hC,   0, 0, 0, 1,    'hA,   0, 2));
    tab.push_back(mk(0, 0, 0,     0, 0, 0, 1,    'hB,   0, 2));
    tab.push_back(mk(0, 0, 0,     0, 0, 0, 1,    'hC,   0, 1));
    tab.push_back(mk(0, 0, 0,     0, 0, 0, 0,    0,     0, 0));
    tab.push_back(mk(0, 1, 'h1,   1, 0, 0, BYP,  'h1,   0, 0));
    tab.push_back(mk(0, 1, 'h2,   1, 0, 0, 1,    'h1,   0, 1));
    tab.push_back(mk(0, 1, 'hD,   0, 0, 1, 0,    0,     1, 2));
    tab.push_back(mk(0, 0, 0,     0, 0, 0, 0,    0,     0, 0));
    tab.push_back(mk(0, 1, 'h5,   1, 0, 0, BYP,  'h5,   0, 0));
    tab.push_back(mk(0, 0, 0,     0, 1, 0, 0,    0,     0, 1));
    tab.push_back(mk(0, 0, 0,     0, 1, 0, 0,    0,     0, 1));
    tab.push_back(mk(0, 0, 0,     0, 1, 0, 0,    0,     0, 1));
    tab.push_back(mk(0, 0, 0,     0, 0, 0, 1,    'h5,   0, 1));
    tab.push_back(mk(0, 0, 0,     0, 0, 0, 0,    0,     0, 0));
    tab.push_back(mk(0, 1, 'hE,   0, 0, 0, BYP,  'hE,   0, 0));
    tab.push_back(mk(0, 0, 0,     0, 0, 0, !BYP, 'hE,   0, BYP ? 0 : 1));
    tab.push_back(mk(0, 0, 0,     0, 0, 0, 0,    0,     0, 0));
    tab.push_back(mk(0, 1, 'h7,   1, 0, 0, BYP,  'h7,   0, 0));
    tab.push_back(mk(1, 1, 'h8,   0, 0, 0, 0,    0,     1, 1));
    tab.push_back(mk(0, 0, 0,     0, 0, 0, 0,    0,     0, 0));
    for (int i = 0; i < tab.size(); i++) step(tab[i], 1'b1, $sformatf("vec%0d", i));

    // Continuous push/pop through DEPTH=3: pointers wrap several times.
    cap_en = 1'b1;
    for (int i = 0; i < 10; i++)
      step(mk(0, 1, W'(64'h30 + i), 0, 0, 0, 0, 0, 0, 0), 1'b0, "stream");
    for (int i = 0; i < 4; i++) step(idle, 1'b0, "drain");
    cap_en = 1'b0;
    cmp("d3 stream length", W'(emitted.size()), W'(10));
    for (int i = 0; i < 10 && i < emitted.size(); i++)
      cmp($sformatf("d3 stream order %0d", i), emitted[i], W'(64'h30 + i));

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      vec_t v;
      v = idle;
      v.rst   = ($urandom_range(0, 99) < 2);
      v.pd    = ($urandom_range(0, 99) < 60);
      v.ns    = ($urandom_range(0, 99) < 35);
      v.hold  = ($urandom_range(0, 99) < 10);
      v.flush = ($urandom_range(0, 99) < 4);
      v.din   = {$urandom, $urandom};
      step(v, 1'b0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_buffer.md
STAGE_BUFFER -- requirements
Module: stage_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 64, payload bits per entry (PC plus instruction word).
REQ-002 SHALL have parameter DEPTH, default 2, number of entries, legal range 1..16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port prev_done  input  1  upstream offers an entry.
REQ-006 SHALL have port stall_prev  output  1  this block refuses the upstream offer.
REQ-007 SHALL have port data_in  input  WIDTH  upstream payload.
REQ-008 SHALL have port next_stall  input  1  downstream refuses the offer.
REQ-009 SHALL have port done_next  output  1  this block offers an entry downstream.
REQ-010 SHALL have port data_out  output  WIDTH  payload offered downstream.
REQ-011 SHALL have port hold  input  1  withhold the head entry (operand contention).
REQ-012 SHALL have port flush  input  1  discard all entries (control-flow redirect).
REQ-013 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-014 SHALL define transfer_prev = prev_done && !stall_prev and transfer_next = done_next && !next_stall; a payload moves only on a transfer.
REQ-015 SHALL store entries in a circular buffer; read and write pointers wrap from DEPTH-1 to 0, including non-power-of-two DEPTH.
REQ-016 SHALL drive stall_prev = rst || (count == DEPTH && !transfer_next), so a full buffer accepts one entry in the same cycle it releases one.
REQ-017 SHALL drive done_next = !rst && !flush && !hold && count != 0.
REQ-018 SHALL drive data_out from the head entry; data_out is don't-care while done_next is low.
REQ-019 SHALL preserve FIFO order, with a minimum latency of 1 cycle from transfer_prev to done_next.
REQ-020 SHALL update count on each clock edge as +1 on transfer_prev only, -1 on transfer_next only, and unchanged on both or neither.
REQ-021 SHALL, on flush, set count to 0 and both pointers equal at the next edge, and SHALL discard any same-cycle transfer_prev entry; stall_prev is unaffected by flush.
REQ-022 SHALL, while hold is high, keep the head entry and count unchanged except for enqueues.
REQ-023 SHALL never drop or duplicate an entry except by flush.

Reset
REQ-024 SHALL, during rst, drive stall_prev=1 and done_next=0, and SHALL set count=0 and pointers=0 at the edge.
REQ-025 SHALL give rst priority over flush and over all transfers; storage contents are not reset.
REQ-026 SHALL, with rst asserted mid-operation, leave the block empty one cycle after rst falls.

Configuration
REQ-027 SHALL, with STAGE_BUFFER_BYPASS_EN defined, when count==0 and !hold and !flush and !rst, drive done_next=prev_done and data_out=data_in combinationally; an entry that transfers both ways in one cycle is not stored (0-cycle latency).
REQ-028 SHALL, without STAGE_BUFFER_BYPASS_EN, keep the 1-cycle minimum latency of REQ-019 with no combinational path from data_in to data_out.

Structure
REQ-029 SHALL take the fetch-to-decode payload struct (pc, pc_valid, instruction, instruction_valid) and its WIDTH constant from the shared package pipeline_pkg.
REQ-030 SHALL need no sub-module; the storage array, pointers and occupancy counter are inline.

Verification
REQ-031 SHALL cover: DEPTH=2; push 0xA, 0xB with next_stall=1 -> count=2, stall_prev=1; release next_stall -> outputs 0xA then 0xB on consecutive cycles.
REQ-032 SHALL cover: full, with push 0xC and pop in the same cycle -> count stays 2; order 0xB, 0xC.
REQ-033 SHALL cover: DEPTH=3; push and pop continuously for 10 entries -> pointers wrap with order intact.
REQ-034 SHALL cover: flush with count=2 and simultaneous push 0xD -> next cycle count=0, done_next=0, 0xD never emitted.
REQ-035 SHALL cover: hold=1 for 3 cycles with count=1 -> done_next=0 throughout; hold released -> head emitted unchanged.
REQ-036 SHALL cover: with bypass on, empty, push 0xE with next_stall=0 -> done_next=1 and data_out=0xE in the same cycle, count stays 0; with bypass off -> emitted one cycle later.
